cordic_angle_sched: RTL and testbench
=====================================

Name: cordic_angle_sched

Overview:
Shares one cordic_angle engine (accel x/y/z in, pitch/roll out, start/done handshake, 16384 = 90°) between two accel-sample requesters. Example requesters: the primary IMU path and the secondary/calibration path.
Per-requester one-entry holding slot, round-robin grant, start pulse generation, done qualification, timeout watchdog with engine reset recovery. Results leave on a single tagged result stream.

Parameters:
DATA_W, 16, signed width of accel operands and angle results
TIMEOUT_CYC, 64, max WAIT cycles before declaring engine hang (engine ITERATIONS=12 plus margin)
RST_CYC, 2, cycles eng_rst_n held low on recovery

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 sample valid
req0_ready  out  1  requester 0 slot empty
req0_x, req0_y, req0_z  in  DATA_W each  requester 0 accel sample (signed)
req1_valid  in  1  requester 1 sample valid
req1_ready  out  1  requester 1 slot empty
req1_x, req1_y, req1_z  in  DATA_W each  requester 1 accel sample (signed)
eng_start  out  1  one-cycle start to engine
eng_x, eng_y, eng_z  out  DATA_W each  engine operands, stable from start until done/timeout
eng_done  in  1  engine done (level or pulse)
eng_pitch, eng_roll  in  DATA_W each  engine results
eng_rst_n  out  1  engine active-low reset
res_valid  out  1  one-cycle result strobe
res_id  out  1  requester tag of result
res_err  out  1  result is a timeout (angles forced 0)
res_pitch, res_roll  out  DATA_W each  captured angles
busy  out  1  state != IDLE

Behaviour:
- Reset values (rst high, sampled on clk): state IDLE; both slots empty, so req*_ready=1; last_grant=1 (req0 wins first tie); eng_start=0; eng_x/y/z=0; res_valid=0; res_id=0; res_err=0; res_pitch=res_roll=0; timeout counter=0.
- eng_rst_n is 0 while rst is high and for RST_CYC cycles after rst falls.
- rst mid-operation: in-flight op is dropped silently, with no res_valid. Both slots are cleared.
- Slot: accept on valid && ready. The slot becomes full the next cycle and ready=0.
- A slot frees (ready=1) the cycle after its sample is copied into eng_x/y/z.
- No overwrite. A requester holds valid while ready=0.
- States:
  - IDLE: if any slot is full, grant and copy its operands to eng_x/y/z, then go to ISSUE. Arbitration:
    - one full slot: grant it.
    - both full: grant the one != last_grant.
    - update last_grant on grant.
    - no full slot: stay in IDLE.
  - ISSUE: eng_start=1 for exactly this cycle; clear timeout counter and done_armed; go to WAIT.
  - WAIT: done_armed is set the first cycle eng_done==0 is seen. A qualified done is eng_done==1 && done_armed, which rejects a stale level-done from the previous op.
    - On qualified done: register res_pitch/res_roll from eng_*, res_id=grant, res_err=0, res_valid=1 next cycle; go to IDLE.
    - Otherwise the counter increments. When counter==TIMEOUT_CYC-1 with no qualified done: res_valid=1, res_err=1, angles 0, res_id=grant; go to RECOVER.
    - Done and timeout in the same cycle: done wins.
  - RECOVER: eng_rst_n=0 for RST_CYC cycles; then go to IDLE.
- Latency: sample accepted at edge k gives grant at k+1, eng_start high in cycle k+1..k+2, slot ready at k+2. res_valid is asserted the cycle after the qualified done.
- Requests arriving during WAIT/RECOVER are buffered in their slot and served in later IDLE passes.
- Arithmetic: no computation; operands and results pass through bit-exact as signed DATA_W.

Decomposition:
- Shared package cordic_pkg: ANGLE_W=16, ANGLE_90=16384, ANGLE_180=32768, state encoding (IDLE, ISSUE, WAIT, RECOVER), requester-id type.
- Sub-module cordic_req_slot: one-entry x/y/z holding register with valid/ready and a pop input. Instantiated twice.
- Top contains the FSM, arbiter, watchdog, and result register.

Test Plan:
1. Bench engine model with latency 14 and pulse done. req0=(0,0,10000) → one eng_start with eng_x=0, eng_y=0, eng_z=10000; res_valid, res_id=0, res_err=0, pitch=0, roll=0; req0_ready back to 1 two cycles after accept.
2. After reset, req0=(10000,0,10000) and req1=(0,-8192,14189) valid in the same cycle → req0 served first, then req1; res_id sequence 0,1; each result matches the model. A second simultaneous pair is served 0,1 again; with last_grant=1 the order alternates correctly.
3. req0 sends two samples back-to-back → second held with ready=0 until the first issues, then accepted; two results with id=0, in order.
4. Model never asserts done → res_valid with res_err=1 and angles 0 exactly TIMEOUT_CYC WAIT cycles after start; eng_rst_n low 2 cycles; next req1 completes normally.
5. Model holds done high continuously between ops → second op does not complete until done drops and rises again; no early res_valid.
6. rst asserted during WAIT → next cycle: all outputs at reset values, no res_valid, both slots empty, eng_rst_n low through rst +2 cycles.

Source files
------------

// File: rtl/cordic_pkg.sv
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared types and constants for the CORDIC angle-engine scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

    localparam int ANGLE_W   = 16;
    localparam int ANGLE_90  = 16384;
    localparam int ANGLE_180 = 32768;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RECOVER = 2'd3
    } sched_state_t;

    typedef logic req_id_t;

    // Round-robin pick: a lone full slot wins, a tie goes to the non-last requester.
    function automatic req_id_t arb_pick(input logic full0, input logic full1, input req_id_t last);
        if (full0 && full1) begin
            return ~last;
        end else if (full1) begin
            return 1'b1;
        end else begin
            return 1'b0;
        end
    endfunction

endpackage : cordic_pkg

`default_nettype wire

// File: rtl/cordic_req_slot.sv
// ============================================================================
// Module   : cordic_req_slot
// Brief    : One-entry x/y/z holding register with valid/ready in and pop out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_req_slot
    import cordic_pkg::*;
#(
    parameter int DATA_W = ANGLE_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic signed [DATA_W-1:0] x_i,
    input  logic signed [DATA_W-1:0] y_i,
    input  logic signed [DATA_W-1:0] z_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic signed [DATA_W-1:0] x_o,
    output logic signed [DATA_W-1:0] y_o,
    output logic signed [DATA_W-1:0] z_o
);

    logic                     full_q, full_d;
    logic signed [DATA_W-1:0] x_q, x_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic signed [DATA_W-1:0] z_q, z_d;
    logic                     accept;

    // Accept and pop are mutually exclusive: accept needs empty, pop needs full.
    always_comb begin
        accept = valid_i && !full_q;
        full_d = full_q;
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        if (accept) begin
            full_d = 1'b1;
            x_d    = x_i;
            y_d    = y_i;
            z_d    = z_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
        end else begin
            full_q <= full_d;
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
        end
    end

    assign ready_o = !full_q;
    assign full_o  = full_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign z_o     = z_q;

endmodule : cordic_req_slot

`default_nettype wire

// File: rtl/cordic_angle_sched.sv
// ============================================================================
// Module   : cordic_angle_sched
// Brief    : Two-requester round-robin scheduler for one cordic_angle engine,
//            with done qualification, hang watchdog and engine reset recovery.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_angle_sched
    import cordic_pkg::*;
#(
    parameter int DATA_W      = ANGLE_W,
    parameter int TIMEOUT_CYC = 64,
    parameter int RST_CYC     = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic signed [DATA_W-1:0] req0_x,
    input  logic signed [DATA_W-1:0] req0_y,
    input  logic signed [DATA_W-1:0] req0_z,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic signed [DATA_W-1:0] req1_x,
    input  logic signed [DATA_W-1:0] req1_y,
    input  logic signed [DATA_W-1:0] req1_z,
    output logic                     eng_start,
    output logic signed [DATA_W-1:0] eng_x,
    output logic signed [DATA_W-1:0] eng_y,
    output logic signed [DATA_W-1:0] eng_z,
    input  logic                     eng_done,
    input  logic signed [DATA_W-1:0] eng_pitch,
    input  logic signed [DATA_W-1:0] eng_roll,
    output logic                     eng_rst_n,
    output logic                     res_valid,
    output logic                     res_id,
    output logic                     res_err,
    output logic signed [DATA_W-1:0] res_pitch,
    output logic signed [DATA_W-1:0] res_roll,
    output logic                     busy
);

    localparam int                CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int                RCNT_W   = $clog2(RST_CYC + 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [RCNT_W-1:0] RST_LOAD = RCNT_W'(RST_CYC);

    sched_state_t             state_q, state_d;
    req_id_t                  grant_q, grant_d;
    req_id_t                  last_grant_q, last_grant_d;
    logic signed [DATA_W-1:0] eng_x_q, eng_x_d;
    logic signed [DATA_W-1:0] eng_y_q, eng_y_d;
    logic signed [DATA_W-1:0] eng_z_q, eng_z_d;
    logic [CNT_W-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic                     done_armed_q, done_armed_d;
    logic [RCNT_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic                     res_valid_q, res_valid_d;
    req_id_t                  res_id_q, res_id_d;
    logic                     res_err_q, res_err_d;
    logic signed [DATA_W-1:0] res_pitch_q, res_pitch_d;
    logic signed [DATA_W-1:0] res_roll_q, res_roll_d;

    logic                     full0, full1, pop0, pop1;
    logic signed [DATA_W-1:0] slot0_x, slot0_y, slot0_z;
    logic signed [DATA_W-1:0] slot1_x, slot1_y, slot1_z;
    logic                     any_full, qual_done, timeout;
    req_id_t                  pick;

    cordic_req_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (req0_valid),
        .ready_o (req0_ready),
        .x_i     (req0_x),
        .y_i     (req0_y),
        .z_i     (req0_z),
        .pop_i   (pop0),
        .full_o  (full0),
        .x_o     (slot0_x),
        .y_o     (slot0_y),
        .z_o     (slot0_z)
    );

    cordic_req_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .valid_i (req1_valid),
        .ready_o (req1_ready),
        .x_i     (req1_x),
        .y_i     (req1_y),
        .z_i     (req1_z),
        .pop_i   (pop1),
        .full_o  (full1),
        .x_o     (slot1_x),
        .y_o     (slot1_y),
        .z_o     (slot1_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_full) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (qual_done) begin
                    state_d = ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: if (rst_cnt_q <= RCNT_W'(1)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // The slot is released while ISSUE drives start, one cycle after the copy.
    always_comb begin
        eng_start = (state_q == ST_ISSUE);
        busy      = (state_q != ST_IDLE);
        pop0      = (state_q == ST_ISSUE) && (grant_q == 1'b0);
        pop1      = (state_q == ST_ISSUE) && (grant_q == 1'b1);
        any_full  = full0 || full1;
        pick      = arb_pick(full0, full1, last_grant_q);
        qual_done = (state_q == ST_WAIT) && eng_done && done_armed_q;
        timeout   = (state_q == ST_WAIT) && !qual_done && (tmo_cnt_q == TO_LAST);
    end

    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        eng_x_d      = eng_x_q;
        eng_y_d      = eng_y_q;
        eng_z_d      = eng_z_q;
        tmo_cnt_d    = tmo_cnt_q;
        done_armed_d = done_armed_q;
        rst_cnt_d    = (rst_cnt_q != '0) ? rst_cnt_q - 1'b1 : rst_cnt_q;
        res_valid_d  = 1'b0;
        res_id_d     = res_id_q;
        res_err_d    = res_err_q;
        res_pitch_d  = res_pitch_q;
        res_roll_d   = res_roll_q;

        if ((state_q == ST_IDLE) && any_full) begin
            grant_d      = pick;
            last_grant_d = pick;
            eng_x_d      = pick ? slot1_x : slot0_x;
            eng_y_d      = pick ? slot1_y : slot0_y;
            eng_z_d      = pick ? slot1_z : slot0_z;
        end

        if (state_q == ST_ISSUE) begin
            tmo_cnt_d    = '0;
            done_armed_d = 1'b0;
        end

        // A level-done left high by the previous op is ignored until it drops once.
        if (state_q == ST_WAIT) begin
            if (!eng_done) begin
                done_armed_d = 1'b1;
            end
            if (qual_done) begin
                res_valid_d = 1'b1;
                res_id_d    = grant_q;
                res_err_d   = 1'b0;
                res_pitch_d = eng_pitch;
                res_roll_d  = eng_roll;
            end else if (timeout) begin
                res_valid_d = 1'b1;
                res_id_d    = grant_q;
                res_err_d   = 1'b1;
                res_pitch_d = '0;
                res_roll_d  = '0;
                rst_cnt_d   = RST_LOAD;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            eng_x_q      <= '0;
            eng_y_q      <= '0;
            eng_z_q      <= '0;
            tmo_cnt_q    <= '0;
            done_armed_q <= 1'b0;
            rst_cnt_q    <= RST_LOAD;
            res_valid_q  <= 1'b0;
            res_id_q     <= 1'b0;
            res_err_q    <= 1'b0;
            res_pitch_q  <= '0;
            res_roll_q   <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            eng_x_q      <= eng_x_d;
            eng_y_q      <= eng_y_d;
            eng_z_q      <= eng_z_d;
            tmo_cnt_q    <= tmo_cnt_d;
            done_armed_q <= done_armed_d;
            rst_cnt_q    <= rst_cnt_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_err_q    <= res_err_d;
            res_pitch_q  <= res_pitch_d;
            res_roll_q   <= res_roll_d;
        end
    end

    // Engine reset covers both system reset and watchdog recovery.
    assign eng_rst_n = !rst && (rst_cnt_q == '0);
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;
    assign eng_z     = eng_z_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_err   = res_err_q;
    assign res_pitch = res_pitch_q;
    assign res_roll  = res_roll_q;

endmodule : cordic_angle_sched

`default_nettype wire

// File: tb/tb_cordic_angle_sched.sv
// ============================================================================
// Module   : tb_cordic_angle_sched
// Brief    : Scoreboard bench for cordic_angle_sched with a behavioural engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_angle_sched;

    localparam int  TIMEOUT_CYC = 64;
    localparam int  RST_CYC     = 2;
    localparam int  ENG_LAT     = 14;
    localparam int  MODE_PULSE  = 0;
    localparam int  MODE_LEVEL  = 1;
    localparam int  MODE_HANG   = 2;
    localparam real PI          = 3.14159265358979323846;

    typedef struct {
        logic               err;
        logic signed [15:0] p;
        logic signed [15:0] r;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               req0_valid, req0_ready, req1_valid, req1_ready;
    logic signed [15:0] req0_x, req0_y, req0_z, req1_x, req1_y, req1_z;
    logic               eng_start, eng_done, eng_rst_n;
    logic signed [15:0] eng_x, eng_y, eng_z, eng_pitch, eng_roll;
    logic               res_valid, res_id, res_err, busy;
    logic signed [15:0] res_pitch, res_roll;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_res    = 0;
    int   cyc      = 0;
    int   last_start = 0;
    int   eng_mode = MODE_PULSE;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   got_ids[$];
    exp_t mon_e;

    cordic_angle_sched #(.DATA_W(16), .TIMEOUT_CYC(TIMEOUT_CYC), .RST_CYC(RST_CYC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y), .eng_z(eng_z),
        .eng_done(eng_done), .eng_pitch(eng_pitch), .eng_roll(eng_roll),
        .eng_rst_n(eng_rst_n),
        .res_valid(res_valid), .res_id(res_id), .res_err(res_err),
        .res_pitch(res_pitch), .res_roll(res_roll), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Engine reference: true pitch/roll in 16384-per-90-degree units.
    function automatic logic signed [15:0] to_ang(input real rad);
        real v;
        int  iv;
        v  = rad * 32768.0 / PI;
        iv = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        return iv[15:0];
    endfunction

    function automatic logic signed [15:0] pitch_of(input logic signed [15:0] x, y, z);
        real rx, ry, rz;
        rx = real'(x); ry = real'(y); rz = real'(z);
        return to_ang($atan2(-rx, $sqrt(ry * ry + rz * rz)));
    endfunction

    function automatic logic signed [15:0] roll_of(input logic signed [15:0] y, z);
        return to_ang($atan2(real'(y), real'(z)));
    endfunction

    // Behavioural engine: pulse, level (stale-high into next op) or hung done.
    initial begin
        int                 lat;
        int                 stale;
        bit                 pend;
        logic signed [15:0] ox, oy, oz;
        eng_done = 1'b0; eng_pitch = '0; eng_roll = '0;
        lat = 0; stale = 0; pend = 1'b0; ox = '0; oy = '0; oz = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!eng_rst_n) begin
                pend = 1'b0; stale = 0; eng_done = 1'b0;
            end else begin
                if (eng_mode != MODE_LEVEL) eng_done = 1'b0;
                if (eng_start) begin
                    ox = eng_x; oy = eng_y; oz = eng_z;
                    lat   = ENG_LAT;
                    pend  = (eng_mode != MODE_HANG);
                    stale = eng_done ? 4 : 0;
                end else begin
                    if (stale > 0) begin
                        stale--;
                        if (stale == 0) eng_done = 1'b0;
                    end
                    if (pend) begin
                        lat--;
                        if (lat == 0) begin
                            eng_done  = 1'b1;
                            eng_pitch = pitch_of(ox, oy, oz);
                            eng_roll  = roll_of(oy, oz);
                            pend      = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: pops the requester's expectation on every result strobe.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (eng_start) last_start = cyc;
        if (!rst && res_valid) begin
            n_res++;
            got_ids.push_back(int'(res_id));
            if ((res_id ? exp_q1.size() : exp_q0.size()) == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = res_id ? exp_q1.pop_front() : exp_q0.pop_front();
                chk("res_err", int'(res_err), int'(mon_e.err));
                chk("res_pitch", int'(res_pitch), int'(mon_e.p));
                chk("res_roll", int'(res_roll), int'(mon_e.r));
                chk("res_latency", cyc - last_start, mon_e.err ? TIMEOUT_CYC + 1 : ENG_LAT + 1);
            end
        end
    end

    task automatic send(input int r, input logic signed [15:0] x, y, z);
        int   k;
        exp_t e;
        k = 0;
        if (r == 0) begin
            req0_x = x; req0_y = y; req0_z = z; req0_valid = 1'b1;
        end else begin
            req1_x = x; req1_y = y; req1_z = z; req1_valid = 1'b1;
        end
        while (((r == 0) ? req0_ready : req1_ready) == 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) chk("send_ready_bound", k, 0);
        e.err = (eng_mode == MODE_HANG);
        e.p   = e.err ? 16'sd0 : pitch_of(x, y, z);
        e.r   = e.err ? 16'sd0 : roll_of(y, z);
        if (r == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        @(negedge clk);
        if (r == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_res(input int target);
        int k;
        k = 0;
        while (n_res < target && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("result_count", n_res, target);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_stream(input int r, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            send(r, 16'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got=expired expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base;
        int saved;
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req0_z = '0;
        req1_x = '0; req1_y = '0; req1_z = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_req0_ready", int'(req0_ready), 1);
        chk("rst_req1_ready", int'(req1_ready), 1);
        chk("rst_eng_start", int'(eng_start), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_eng_x", int'(eng_x), 0);
        chk("rst_eng_rst_n", int'(eng_rst_n), 0);
        rst = 1'b0;
        chk("rst_rel_eng_rst_n0", int'(eng_rst_n), 0);
        @(negedge clk);
        chk("rst_rel_eng_rst_n1", int'(eng_rst_n), 0);
        @(negedge clk);
        chk("rst_rel_eng_rst_n2", int'(eng_rst_n), 1);

        // Single op: timing of start and slot release
        send(0, 16'sd0, 16'sd0, 16'sd10000);
        chk("t1_ready_after_accept", int'(req0_ready), 0);
        @(negedge clk);
        chk("t1_eng_start", int'(eng_start), 1);
        chk("t1_eng_x", int'(eng_x), 0);
        chk("t1_eng_y", int'(eng_y), 0);
        chk("t1_eng_z", int'(eng_z), 10000);
        chk("t1_ready_issue", int'(req0_ready), 0);
        @(negedge clk);
        chk("t1_ready_free", int'(req0_ready), 1);
        chk("t1_start_single", int'(eng_start), 0);
        wait_res(1);
        chk("t1_id", got_ids[0], 0);

        // Simultaneous pairs after reset: order 0,1 then 0,1 again
        do_reset();
        for (int p = 0; p < 2; p++) begin
            base = n_res;
            fork
                send(0, 16'sd10000, 16'sd0, 16'sd10000);
                send(1, 16'sd0, -16'sd8192, 16'sd14189);
            join
            wait_res(base + 2);
            chk("t2_first_id", got_ids[base], 0);
            chk("t2_second_id", got_ids[base + 1], 1);
        end

        // Back-to-back from one requester
        base = n_res;
        send(0, 16'sd3000, 16'sd2000, 16'sd9000);
        chk("t3_held_not_ready", int'(req0_ready), 0);
        send(0, -16'sd5000, 16'sd7000, -16'sd4000);
        wait_res(base + 2);
        chk("t3_id_a", got_ids[base], 0);
        chk("t3_id_b", got_ids[base + 1], 0);

        // Hung engine: timeout result and engine reset pulse
        eng_mode = MODE_HANG;
        base = n_res;
        send(0, 16'sd1234, 16'sd4321, 16'sd8000);
        wait_res(base + 1);
        chk("t4_eng_rst_n_a", int'(eng_rst_n), 0);
        @(negedge clk);
        chk("t4_eng_rst_n_b", int'(eng_rst_n), 0);
        @(negedge clk);
        chk("t4_eng_rst_n_c", int'(eng_rst_n), 1);
        eng_mode = MODE_PULSE;
        send(1, 16'sd500, -16'sd600, 16'sd12000);
        wait_res(base + 2);
        chk("t4_recover_id", got_ids[base + 1], 1);

        // Level done held across ops: stale level must not complete op 2
        eng_mode = MODE_LEVEL;
        base = n_res;
        send(0, 16'sd6000, 16'sd1000, 16'sd11000);
        wait_res(base + 1);
        send(1, -16'sd9000, 16'sd3000, 16'sd7000);
        wait_res(base + 2);
        eng_mode = MODE_PULSE;
        repeat (2) @(negedge clk);

        // Reset during WAIT with the other slot occupied
        saved = n_res;
        send(0, 16'sd7000, 16'sd7000, 16'sd7000);
        repeat (3) @(negedge clk);
        send(1, 16'sd100, 16'sd200, 16'sd300);
        chk("t6_busy_before", int'(busy), 1);
        chk("t6_slot1_full", int'(req1_ready), 0);
        rst = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        chk("t6_res_valid", int'(res_valid), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_eng_start", int'(eng_start), 0);
        chk("t6_req0_ready", int'(req0_ready), 1);
        chk("t6_req1_ready", int'(req1_ready), 1);
        chk("t6_eng_x", int'(eng_x), 0);
        chk("t6_eng_z", int'(eng_z), 0);
        chk("t6_res_pitch", int'(res_pitch), 0);
        chk("t6_res_roll", int'(res_roll), 0);
        chk("t6_res_id", int'(res_id), 0);
        chk("t6_eng_rst_n", int'(eng_rst_n), 0);
        rst = 1'b0;
        chk("t6_rel_rst_n0", int'(eng_rst_n), 0);
        @(negedge clk);
        chk("t6_rel_rst_n1", int'(eng_rst_n), 0);
        @(negedge clk);
        chk("t6_rel_rst_n2", int'(eng_rst_n), 1);
        repeat (40) @(negedge clk);
        chk("t6_no_result", n_res, saved);

        // Randomized traffic from both requesters
        base = n_res;
        fork
            rand_stream(0, 8);
            rand_stream(1, 8);
        join
        wait_res(base + 16);
        repeat (5) @(negedge clk);
        chk("end_q0_empty", exp_q0.size(), 0);
        chk("end_q1_empty", exp_q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cordic_angle_sched

`default_nettype wire
